t_latch_bank: RTL and testbench
===============================

Name: t_latch_bank

Overview:
- Multi-channel, width-parametrised latch bank; successor to the single-bit transparent latch primitive.
- Latches are built as clocked storage plus an output mux, so no inferred latches and no tool "inferring latch" warnings.
- Adds registered and staged/atomic-commit modes, and a serial snapshot readout port.
- Used for control/status words crossing from CPU-side command decode into DSP channel blocks (per-channel frequency/gain words), where several channels must change in the same cycle.

Parameters:
- WIDTH, 8, bits per channel.
- CHANNELS, 4, number of channels (>=1).
- RESET_VAL, 0, reset value of every held and shadow word (WIDTH bits).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous reset, active-low.
- mode  in  2  0=TRANSPARENT, 1=REGISTERED, 2=STAGED, 3=reserved (behaves as REGISTERED).
- en  in  CHANNELS  per-channel write enable.
- d  in  CHANNELS*WIDTH  per-channel data; channel i at [i*WIDTH +: WIDTH].
- commit  in  1  STAGED mode: transfer pending shadows to held words.
- q  out  CHANNELS*WIDTH  per-channel output (combinational mux of held/d).
- pending  out  CHANNELS  shadow written but not yet committed.
- snap_req  in  1  request snapshot of q.
- snap_busy  out  1  snapshot capture/readout in progress.
- snap_valid  out  1  snap_dout valid this cycle.
- snap_last  out  1  marks last channel of snapshot.
- snap_dout  out  WIDTH  snapshot word, channel order 0..CHANNELS-1.

Behaviour:
- Reset (rst_n low, async): held[i]=RESET_VAL; shadow[i]=RESET_VAL; pending=0; snapshot FSM=IDLE; snap_busy=0; snap_valid=0; snap_last=0; snap_dout=0.
  - q follows the mode mux during reset (TRANSPARENT with en=1 shows d; otherwise RESET_VAL).
- TRANSPARENT (0):
  - q[i] = en[i] ? d[i] : held[i], zero-latency combinational path.
  - posedge with en[i]=1: held[i]<=d[i].
- REGISTERED (1, 3):
  - q[i]=held[i].
  - en[i]=1: held[i]<=d[i]; q reflects the new value one cycle later.
- STAGED (2):
  - q[i]=held[i].
  - en[i]=1: shadow[i]<=d[i]; pending[i]<=1.
  - commit=1: for every i with pending[i]=1 or en[i]=1, held[i]<= (en[i] ? d[i] : shadow[i]); pending<=0.
  - A write in the commit cycle is included in that commit.
  - All committed channels change q in the same cycle.
  - commit with pending=0 and en=0: no effect.
- commit is ignored when mode!=2.
- Any cycle with mode!=2: pending<=0 (uncommitted shadows discarded; shadow contents kept but unused).
- Mode changes take effect on the combinational q immediately; held words are unaffected by mode changes.
- Snapshot FSM, states IDLE and SHIFT:
  - IDLE, snap_req=1 at posedge: snap_buf[i]<=q[i] for all i (q value in that cycle, including transparent d); cnt<=0; ->SHIFT; snap_busy<=1.
  - SHIFT, each cycle: snap_valid=1; snap_dout=snap_buf[cnt]; snap_last=(cnt==CHANNELS-1).
    - cnt increments each cycle.
    - After the last word: ->IDLE, with snap_busy and snap_valid deasserting the following cycle.
  - Latency: first word valid 1 cycle after the snap_req edge. CHANNELS words are delivered in consecutive cycles with no backpressure.
  - snap_req while snap_busy=1: ignored, not queued.
  - snap_req in the cycle after snap_last: accepted (back-to-back snapshots permitted).
  - CHANNELS=1: single word with snap_valid and snap_last both high.
- Snapshot outputs (snap_valid, snap_last, snap_dout) are registered. snap_dout=0 when snap_valid=0.
- Latch writes/commits during SHIFT do not alter the snapshot in flight.
- Reset asserted mid-SHIFT: FSM immediately returns to IDLE and all snapshot outputs clear.
- cnt width: clog2(CHANNELS), minimum 1; no wrap beyond CHANNELS-1.

Test Plan:
- Reset/TRANSPARENT (WIDTH=8, CHANNELS=4, RESET_VAL=8'h00):
  - Release reset, mode=0, en=4'b0001, d ch0=8'hA5 -> q ch0=A5 same cycle.
  - Drop en -> q ch0 stays A5; ch1..3=00.
- REGISTERED:
  - mode=1, en=4'b0010, d ch1=8'h3C for one cycle -> q ch1 is 00 in the write cycle, 3C from the next cycle.
  - ch0 unchanged.
- STAGED atomic commit:
  - mode=2; write ch0=11, ch2=22 on separate cycles -> pending=4'b0101, q unchanged.
  - commit with en ch3=33 same cycle -> next cycle q ch0=11, ch2=22, ch3=33 simultaneously; pending=0.
- Mode-exit discard:
  - mode=2, write ch1=77 (pending=4'b0010).
  - mode=1 one cycle, back to mode=2, commit -> pending=0, q ch1 unchanged.
- Snapshot:
  - q={44,33,22,11} (ch3..ch0); pulse snap_req -> next 4 cycles snap_dout=11,22,33,44 with snap_valid=1, snap_last only on 44.
  - snap_req during the burst is ignored.
  - Writing ch0=FF mid-burst does not change the remaining words.
- Reset mid-snapshot:
  - Assert rst_n=0 during the 2nd word -> snap_busy/snap_valid/snap_last=0 immediately, q=RESET_VAL.
  - After release, a new snap_req returns 00,00,00,00.

Source files
------------

// File: rtl/t_latch_bank.sv
// Multi-channel latch bank (transparent/registered/staged-commit); q is combinational, snapshot words start 1 cycle after snap_req.
// Snapshot readout has no backpressure: CHANNELS words stream back-to-back, and requests made while busy are dropped.
module t_latch_bank #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      commit,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       pending,
  input  logic                      snap_req,
  output logic                      snap_busy,
  output logic                      snap_valid,
  output logic                      snap_last,
  output logic [WIDTH-1:0]          snap_dout
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);

  typedef enum logic {S_IDLE, S_SHIFT} snap_state_t;

  logic [WIDTH-1:0]          r_held   [CHANNELS];
  logic [WIDTH-1:0]          r_shadow [CHANNELS];
  logic [WIDTH-1:0]          r_buf    [CHANNELS];
  logic [CHANNELS-1:0]       r_pending;
  logic [CW-1:0]             r_cnt;
  logic                      r_valid;
  logic                      r_last;
  logic [WIDTH-1:0]          r_dout;
  snap_state_t               r_state;
  snap_state_t               w_state_nxt;
  logic [CHANNELS*WIDTH-1:0] w_q;
  logic [CW-1:0]             w_cnt_nxt;
  logic                      w_load;
  logic                      w_done;
  logic                      w_staged;
  logic                      w_transp;

  assign w_staged = (mode == 2'd2);
  assign w_transp = (mode == 2'd0);

  // Only TRANSPARENT exposes d directly; every other mode shows the held word.
  always_comb begin
    w_q = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_q[i*WIDTH +: WIDTH] = (w_transp && en[i]) ? d[i*WIDTH +: WIDTH] : r_held[i];
    end
  end

  assign q       = w_q;
  assign pending = r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_held[i]   <= RESET_VAL;
        r_shadow[i] <= RESET_VAL;
      end
      r_pending <= '0;
    end else if (w_staged) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (en[i]) begin
          r_shadow[i]  <= d[i*WIDTH +: WIDTH];
          r_pending[i] <= 1'b1;
        end
        // A write landing in the commit cycle bypasses the shadow and commits directly.
        if (commit) begin
          if (en[i]) begin
            r_held[i] <= d[i*WIDTH +: WIDTH];
          end else if (r_pending[i]) begin
            r_held[i] <= r_shadow[i];
          end
          r_pending[i] <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (en[i]) begin
          r_held[i] <= d[i*WIDTH +: WIDTH];
        end
      end
      r_pending <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (snap_req) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == LAST_IDX) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_cnt_nxt = r_cnt + 1'b1;

  // Word 0 is presented straight from q at the capture edge; later words come from the frozen buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_buf[i] <= RESET_VAL;
      end
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_dout  <= '0;
    end else if (w_load) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_buf[i] <= w_q[i*WIDTH +: WIDTH];
      end
      r_cnt   <= '0;
      r_valid <= 1'b1;
      r_last  <= (CHANNELS == 1);
      r_dout  <= w_q[WIDTH-1:0];
    end else if (w_done) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_dout  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_cnt  <= w_cnt_nxt;
      r_dout <= r_buf[w_cnt_nxt];
      r_last <= (w_cnt_nxt == LAST_IDX);
    end
  end

  assign snap_busy  = (r_state == S_SHIFT);
  assign snap_valid = r_valid;
  assign snap_last  = r_last;
  assign snap_dout  = r_dout;

endmodule

// File: tb/tb_t_latch_bank.sv
module tb_t_latch_bank;

  localparam int W = 8;
  localparam int C = 4;

  logic           clk;
  logic           rst_n;
  logic [1:0]     mode;
  logic [C-1:0]   en;
  logic [C*W-1:0] d;
  logic           commit;
  logic [C*W-1:0] q;
  logic [C-1:0]   pending;
  logic           snap_req;
  logic           snap_busy;
  logic           snap_valid;
  logic           snap_last;
  logic [W-1:0]   snap_dout;

  int total = 0;
  int bad   = 0;

  // Scoreboard entry: {last, dout}
  logic [W:0] sb_q[$];

  t_latch_bank #(.WIDTH(W), .CHANNELS(C), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .d(d), .commit(commit),
    .q(q), .pending(pending), .snap_req(snap_req), .snap_busy(snap_busy),
    .snap_valid(snap_valid), .snap_last(snap_last), .snap_dout(snap_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_snap(input logic [31:0] words);
    for (int i = 0; i < C; i++) begin
      logic [W-1:0] w;
      w = words[i*W +: W];
      sb_q.push_back({(i == C-1), w});
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((snap_busy || sb_q.size() != 0) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL %s: timeout busy=%0d queued=%0d expected idle", name, snap_busy, sb_q.size());
    end
  endtask

  // Monitor: every valid snapshot word must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && snap_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL snap_unexpected: got dout=%h last=%0d expected no word", snap_dout, snap_last);
      end else begin
        logic [W:0] e;
        e = sb_q.pop_front();
        total++;
        if ({snap_last, snap_dout} !== e) begin
          bad++;
          $display("FAIL snap_word: got last=%0d dout=%h expected last=%0d dout=%h",
                   snap_last, snap_dout, e[W], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; mode = 2'd0; en = '0; d = '0; commit = 1'b0; snap_req = 1'b0;
    #2;
    chk("reset_q", q, 32'h0000_0000);
    chk("reset_pending", {28'd0, pending}, 32'd0);
    chk("reset_snap", {28'd0, snap_busy, snap_valid, snap_last, 1'b0}, 32'd0);
    chk("reset_dout", {24'd0, snap_dout}, 32'd0);
    en = 4'b0001; d = 32'h0000_005A;
    #1;
    chk("reset_transparent_q", q, 32'h0000_005A);
    en = '0; d = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    // TRANSPARENT
    mode = 2'd0; en = 4'b0001; d = 32'h1234_56A5;
    #1;
    chk("transp_same_cycle", q, 32'h0000_00A5);
    step();
    en = '0; d = 32'h9999_9999;
    #1;
    chk("transp_hold", q, 32'h0000_00A5);

    // REGISTERED
    mode = 2'd1; en = 4'b0010; d = 32'h0000_3C00;
    #1;
    chk("reg_write_cycle", q, 32'h0000_00A5);
    step();
    en = '0; d = '0;
    #1;
    chk("reg_next_cycle", q, 32'h0000_3CA5);

    // STAGED atomic commit
    mode = 2'd2; en = 4'b0001; d = 32'h0000_0011;
    step();
    en = 4'b0100; d = 32'h0022_0000;
    step();
    en = '0; d = '0;
    #1;
    chk("staged_pending", {28'd0, pending}, 32'h5);
    chk("staged_q_unchanged", q, 32'h0000_3CA5);
    commit = 1'b1; en = 4'b1000; d = 32'h3300_0000;
    #1;
    chk("staged_commit_cycle_q", q, 32'h0000_3CA5);
    step();
    commit = 1'b0; en = '0; d = '0;
    #1;
    chk("staged_committed_q", q, 32'h3322_3C11);
    chk("staged_pending_clear", {28'd0, pending}, 32'h0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("staged_empty_commit", q, 32'h3322_3C11);

    // Mode-exit discard
    en = 4'b0010; d = 32'h0000_7700;
    step();
    en = '0; d = '0;
    chk("exit_pending_set", {28'd0, pending}, 32'h2);
    mode = 2'd1;
    step();
    chk("exit_pending_discard", {28'd0, pending}, 32'h0);
    mode = 2'd2; commit = 1'b1;
    step();
    commit = 1'b0;
    chk("exit_q_unchanged", q, 32'h3322_3C11);

    // Snapshot with ignored request and mid-burst write
    mode = 2'd1; en = 4'b1111; d = 32'h4433_2211;
    step();
    en = '0; d = '0;
    chk("snap_setup_q", q, 32'h4433_2211);
    snap_req = 1'b1;
    push_snap(32'h4433_2211);
    step();
    snap_req = 1'b1; en = 4'b0001; d = 32'h0000_00FF;
    chk("snap_busy_asserted", {31'd0, snap_busy}, 32'd1);
    step();
    snap_req = 1'b0; en = '0; d = '0;
    begin
      int n;
      n = 0;
      while (!snap_last && n < 10) begin
        step();
        n++;
      end
    end
    chk("snap_last_seen", {31'd0, snap_last}, 32'd1);
    step();
    snap_req = 1'b1;
    push_snap(32'h4433_22FF);
    step();
    snap_req = 1'b0;
    wait_idle("snap_b2b");
    chk("snap_after_q", q, 32'h4433_22FF);

    // Reset mid-snapshot
    snap_req = 1'b1;
    push_snap(32'h4433_22FF);
    step();
    snap_req = 1'b0;
    step();
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_snap", {29'd0, snap_busy, snap_valid, snap_last}, 32'd0);
    chk("midrst_dout", {24'd0, snap_dout}, 32'd0);
    chk("midrst_q", q, 32'h0000_0000);
    step();
    rst_n = 1'b1;
    step();
    snap_req = 1'b1;
    push_snap(32'h0000_0000);
    step();
    snap_req = 1'b0;
    wait_idle("snap_after_reset");
    step();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
